// File: rtl/vt52_host_encoder.sv
// VT52 host-side encoder: turns keyboard events and identify requests into
// the byte stream sent to the host. ASCII passes through as one byte; cursor
// and PF keys expand to two-byte escape sequences; an identify request
// produces the three-byte reply Esc / ID_CHAR.
//
// state | meaning
// IDLE  | no sequence in flight; identify reply or key may be loaded
// SEND  | presenting seq_buf[seq_idx] on tx_data until the last byte transfers
module vt52_host_encoder #(
    parameter logic [7:0] ID_CHAR   = 8'h4B,
    parameter bit         PF_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       ident_req,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] ESC = 8'h1B;

    state_t     state;
    logic [7:0] seq_buf [3];
    logic [1:0] seq_len;
    logic [1:0] seq_idx;
    logic       ident_pending;

    logic       dec_emit;
    logic [1:0] dec_len;
    logic [7:0] dec_b0;
    logic [7:0] dec_b1;
    logic [1:0] next_idx;
    logic [7:0] next_byte;

    // Key is only taken while idle with no identify reply waiting; held low in reset.
    assign key_ready = clr_n && (state == IDLE) && !ident_pending && !ident_req;
    assign busy      = (state == SEND) || ident_pending;

    // Map a key event onto its byte sequence; unmapped codes emit nothing.
    always_comb begin
        dec_emit = 1'b0;
        dec_len  = 2'd1;
        dec_b0   = key_code;
        dec_b1   = 8'h00;
        if (!key_code[7]) begin
            dec_emit = 1'b1;
        end else begin
            case (key_code[6:0])
                7'h00: begin dec_emit = 1'b1; dec_len = 2'd2; dec_b0 = ESC; dec_b1 = 8'h41; end
                7'h01: begin dec_emit = 1'b1; dec_len = 2'd2; dec_b0 = ESC; dec_b1 = 8'h42; end
                7'h02: begin dec_emit = 1'b1; dec_len = 2'd2; dec_b0 = ESC; dec_b1 = 8'h43; end
                7'h03: begin dec_emit = 1'b1; dec_len = 2'd2; dec_b0 = ESC; dec_b1 = 8'h44; end
                7'h04: begin dec_emit = PF_ENABLE; dec_len = 2'd2; dec_b0 = ESC; dec_b1 = 8'h50; end
                7'h05: begin dec_emit = PF_ENABLE; dec_len = 2'd2; dec_b0 = ESC; dec_b1 = 8'h51; end
                7'h06: begin dec_emit = PF_ENABLE; dec_len = 2'd2; dec_b0 = ESC; dec_b1 = 8'h52; end
                default: dec_emit = 1'b0;
            endcase
        end
    end

    // Byte that follows the one currently on tx_data.
    always_comb begin
        next_idx = seq_idx + 2'd1;
        case (next_idx)
            2'd1:    next_byte = seq_buf[1];
            2'd2:    next_byte = seq_buf[2];
            default: next_byte = seq_buf[0];
        endcase
    end

    // Sequencer: load in IDLE (identify before key), step through bytes in SEND.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state         <= IDLE;
            seq_buf[0]    <= 8'h00;
            seq_buf[1]    <= 8'h00;
            seq_buf[2]    <= 8'h00;
            seq_len       <= 2'd0;
            seq_idx       <= 2'd0;
            ident_pending <= 1'b0;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ident_pending || ident_req) begin
                        seq_buf[0]    <= ESC;
                        seq_buf[1]    <= 8'h2F;
                        seq_buf[2]    <= ID_CHAR;
                        seq_len       <= 2'd3;
                        seq_idx       <= 2'd0;
                        tx_data       <= ESC;
                        tx_valid      <= 1'b1;
                        ident_pending <= 1'b0;
                        state         <= SEND;
                    end else if (key_valid && dec_emit) begin
                        seq_buf[0] <= dec_b0;
                        seq_buf[1] <= dec_b1;
                        seq_buf[2] <= 8'h00;
                        seq_len    <= dec_len;
                        seq_idx    <= 2'd0;
                        tx_data    <= dec_b0;
                        tx_valid   <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (ident_req) begin
                        ident_pending <= 1'b1;
                    end
                    if (tx_ready) begin
                        if (seq_idx == seq_len - 2'd1) begin
                            tx_valid <= 1'b0;
                            seq_idx  <= 2'd0;
                            state    <= IDLE;
                        end else begin
                            seq_idx <= next_idx;
                            tx_data <= next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vt52_host_encoder.sv
// Bench for vt52_host_encoder: scoreboard of expected host bytes plus a table
// of key codes and a few hand-written multi-cycle sequences.
module tb_vt52_host_encoder;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       ident_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    logic [7:0] key_code2;
    logic       key_valid2;
    logic       key_ready2;
    logic       ident_req2;
    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       busy2;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q [$];

    typedef struct packed {
        logic [7:0] code;
        logic [1:0] n;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;
    vec_t vecs [14];

    vt52_host_encoder #(.ID_CHAR(8'h4B), .PF_ENABLE(1'b1)) dut (
        .clk(clk), .clr_n(clr_n), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .ident_req(ident_req), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    vt52_host_encoder #(.ID_CHAR(8'h4B), .PF_ENABLE(1'b0)) dut_nopf (
        .clk(clk), .clr_n(clr_n), .key_code(key_code2), .key_valid(key_valid2),
        .key_ready(key_ready2), .ident_req(ident_req2), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every host-side transfer must match the next expected byte.
    always @(negedge clk) begin
        if (clr_n && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_byte: got %0h expected none at %0t", tx_data, $time);
            end else begin
                check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // The PF-disabled instance is only ever fed codes that emit nothing.
    always @(negedge clk) begin
        if (clr_n && tx_valid2) begin
            total++;
            $display("FAIL nopf_output: got %0h expected none at %0t", tx_data2, $time);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept;
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_ready) begin ok = 1; break; end
        end
        check("key_accept", {31'h0, ok}, 32'h1);
        tick;
        key_valid = 1'b0;
    endtask

    task automatic send_key(input logic [7:0] code);
        tick;
        key_code  = code;
        key_valid = 1'b1;
        wait_accept;
    endtask

    task automatic drain;
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !tx_valid) begin ok = 1; break; end
        end
        check("drain", {31'h0, ok}, 32'h1);
    endtask

    initial begin
        vecs[0]  = '{8'h00, 2'd1, 8'h00, 8'h00};
        vecs[1]  = '{8'h41, 2'd1, 8'h41, 8'h00};
        vecs[2]  = '{8'h7F, 2'd1, 8'h7F, 8'h00};
        vecs[3]  = '{8'h0D, 2'd1, 8'h0D, 8'h00};
        vecs[4]  = '{8'h80, 2'd2, 8'h1B, 8'h41};
        vecs[5]  = '{8'h81, 2'd2, 8'h1B, 8'h42};
        vecs[6]  = '{8'h82, 2'd2, 8'h1B, 8'h43};
        vecs[7]  = '{8'h83, 2'd2, 8'h1B, 8'h44};
        vecs[8]  = '{8'h84, 2'd2, 8'h1B, 8'h50};
        vecs[9]  = '{8'h85, 2'd2, 8'h1B, 8'h51};
        vecs[10] = '{8'h86, 2'd2, 8'h1B, 8'h52};
        vecs[11] = '{8'h87, 2'd0, 8'h00, 8'h00};
        vecs[12] = '{8'hFF, 2'd0, 8'h00, 8'h00};
        vecs[13] = '{8'hA5, 2'd0, 8'h00, 8'h00};

        clr_n = 1'b0; key_code = 8'h00; key_valid = 1'b0; ident_req = 1'b0; tx_ready = 1'b1;
        key_code2 = 8'h00; key_valid2 = 1'b0; ident_req2 = 1'b0; tx_ready2 = 1'b1;

        // Reset values
        #23;
        check("rst_tx_valid",  {31'h0, tx_valid},  32'h0);
        check("rst_tx_data",   {24'h0, tx_data},   32'h0);
        check("rst_key_ready", {31'h0, key_ready}, 32'h0);
        check("rst_busy",      {31'h0, busy},      32'h0);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("idle_key_ready", {31'h0, key_ready}, 32'h1);

        // ASCII 'A': one byte, one cycle after accept
        exp_q.push_back(8'h41);
        tick; key_code = 8'h41; key_valid = 1'b1;
        @(negedge clk); check("a_ready", {31'h0, key_ready}, 32'h1);
        tick; key_valid = 1'b0;
        @(negedge clk);
        check("a_valid", {31'h0, tx_valid}, 32'h1);
        check("a_data",  {24'h0, tx_data},  32'h41);
        check("a_ready_send", {31'h0, key_ready}, 32'h0);
        @(negedge clk);
        check("a_valid_off", {31'h0, tx_valid},  32'h0);
        check("a_ready_back", {31'h0, key_ready}, 32'h1);

        // Cursor up: back-to-back Esc A
        exp_q.push_back(8'h1B); exp_q.push_back(8'h41);
        send_key(8'h80);
        @(negedge clk);
        check("up_b0", {24'h0, tx_data}, 32'h1B);
        check("up_ready0", {31'h0, key_ready}, 32'h0);
        @(negedge clk);
        check("up_v1", {31'h0, tx_valid}, 32'h1);
        check("up_b1", {24'h0, tx_data}, 32'h41);
        check("up_ready1", {31'h0, key_ready}, 32'h0);
        @(negedge clk);
        check("up_valid_off", {31'h0, tx_valid}, 32'h0);

        // Identify wins over a simultaneous key; key follows afterwards
        exp_q.push_back(8'h1B); exp_q.push_back(8'h2F); exp_q.push_back(8'h4B);
        exp_q.push_back(8'h1B); exp_q.push_back(8'h44);
        tick; ident_req = 1'b1; key_code = 8'h83; key_valid = 1'b1;
        @(negedge clk); check("id_key_blocked", {31'h0, key_ready}, 32'h0);
        tick; ident_req = 1'b0;
        @(negedge clk); check("id_first", {24'h0, tx_data}, 32'h1B);
        wait_accept;
        drain;

        // PF1 with a 5-cycle stall on the second byte
        exp_q.push_back(8'h1B); exp_q.push_back(8'h50);
        send_key(8'h84);
        tick; tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("pf_stall_valid", {31'h0, tx_valid}, 32'h1);
            check("pf_stall_data",  {24'h0, tx_data},  32'h50);
            @(posedge clk);
        end
        #1 tx_ready = 1'b1;
        drain;

        // PF1 dropped when PF keys are disabled
        tick; key_code2 = 8'h84; key_valid2 = 1'b1;
        @(negedge clk); check("nopf_ready", {31'h0, key_ready2}, 32'h1);
        tick; key_valid2 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("nopf_valid", {31'h0, tx_valid2}, 32'h0);
            check("nopf_busy",  {31'h0, busy2},     32'h0);
        end

        // Three identify pulses during a stalled key sequence coalesce
        exp_q.push_back(8'h1B); exp_q.push_back(8'h42);
        exp_q.push_back(8'h1B); exp_q.push_back(8'h2F); exp_q.push_back(8'h4B);
        tx_ready = 1'b0;
        send_key(8'h81);
        repeat (3) begin
            repeat (2) tick;
            ident_req = 1'b1;
            tick;
            ident_req = 1'b0;
        end
        @(negedge clk);
        check("coal_busy", {31'h0, busy},    32'h1);
        check("coal_hold", {24'h0, tx_data}, 32'h1B);
        tick; tx_ready = 1'b1;
        drain;
        send_key(8'h90);
        repeat (4) begin
            @(negedge clk);
            check("k90_silent", {31'h0, tx_valid}, 32'h0);
        end
        drain;

        // Reset during stalled second byte of Esc B
        exp_q.push_back(8'h1B);
        send_key(8'h81);
        tick; tx_ready = 1'b0;
        repeat (2) tick;
        check("rst_pre_valid", {31'h0, tx_valid}, 32'h1);
        check("rst_pre_data",  {24'h0, tx_data},  32'h42);
        clr_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'h0, tx_valid},  32'h0);
        check("rst_mid_busy",  {31'h0, busy},      32'h0);
        check("rst_mid_ready", {31'h0, key_ready}, 32'h0);
        repeat (2) tick;
        @(negedge clk);
        clr_n = 1'b1; tx_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_post_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_post_busy",  {31'h0, busy},     32'h0);
        drain;

        // Table of key codes
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].n >= 2'd1) exp_q.push_back(vecs[i].b0);
            if (vecs[i].n >= 2'd2) exp_q.push_back(vecs[i].b1);
            send_key(vecs[i].code);
            drain;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
